// File: rtl/tile_draw_arbiter.sv
// Round-robin arbiter that owns the VGA pixel-write port and paints one
// 4-tile row per grant. Optional macro TILE_BORDER_EN draws black tile borders.
module tile_draw_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          TILE_W   = 40,
  parameter int          TILE_H   = 30,
  parameter int          COLS     = 4,
  parameter logic [8:0]  BG_COLOR = 9'h05a,
  parameter logic [8:0]  FG_COLOR = 9'h1ff
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   row_y,
  input  logic [COLS*NUM_REQ-1:0] pattern,
  input  logic [NUM_REQ-1:0]     accent_en,
  input  logic [9*NUM_REQ-1:0]   accent_color,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic                   plot,
  output logic [7:0]             VGA_X,
  output logic [6:0]             VGA_Y,
  output logic [8:0]             VGA_COLOR
);

  // state  | meaning
  // IDLE   | waiting for any req, round-robin pick from rr_ptr
  // LATCH  | grant asserted, descriptor captured, first pixel issued
  // DRAW   | one plot per cycle over the whole row
  // DONE   | done pulse on the granted bit, advance rr_ptr
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(COLS);
  localparam int XW = $clog2(TILE_W);
  localparam int YW = $clog2(TILE_H);

  logic [1:0]      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   g_idx;
  logic [1:0]      row_q;
  logic [COLS-1:0] pat_q;
  logic            acc_en_q;
  logic [8:0]      acc_col_q;
  logic [CW-1:0]   col;
  logic [XW-1:0]   xoff;
  logic [YW-1:0]   yoff;

  logic [IW-1:0]   sel_idx;
  logic            sel_found;
  logic [IW:0]     cand;

  logic            x_last, y_last, c_last, row_last;
  logic [CW-1:0]   col_n;
  logic [XW-1:0]   xoff_n;
  logic [YW-1:0]   yoff_n;

  logic [CW-1:0]   s_col;
  logic [XW-1:0]   s_x;
  logic [YW-1:0]   s_y;
  logic [1:0]      s_row;
  logic [COLS-1:0] s_pat;
  logic            s_aen;
  logic [8:0]      s_acol;

  logic [7:0]      px_x;
  logic [6:0]      px_y;
  logic [8:0]      px_color;

  assign busy = (state != S_IDLE);

  always_comb begin
    sel_idx   = rr_ptr;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!sel_found && req[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    x_last   = (xoff == XW'(TILE_W-1));
    y_last   = (yoff == YW'(TILE_H-1));
    c_last   = (col  == CW'(COLS-1));
    row_last = x_last && y_last && c_last;
    xoff_n   = x_last ? '0 : xoff + 1'b1;
    yoff_n   = yoff;
    col_n    = col;
    if (x_last) begin
      yoff_n = y_last ? '0 : yoff + 1'b1;
      if (y_last) col_n = col + 1'b1;
    end
  end

  // The first pixel leaves in LATCH, so it must come from the live inputs
  // rather than the descriptor registers still being loaded.
  always_comb begin
    if (state == S_LATCH) begin
      s_col  = '0;
      s_x    = '0;
      s_y    = '0;
      s_row  = row_y[int'(g_idx)*2 +: 2];
      s_pat  = pattern[int'(g_idx)*COLS +: COLS];
      s_aen  = accent_en[g_idx];
      s_acol = accent_color[int'(g_idx)*9 +: 9];
    end else begin
      s_col  = col_n;
      s_x    = xoff_n;
      s_y    = yoff_n;
      s_row  = row_q;
      s_pat  = pat_q;
      s_aen  = acc_en_q;
      s_acol = acc_col_q;
    end
  end

  always_comb begin
    px_x = 8'(s_col) * 8'(TILE_W) + 8'(s_x);
    px_y = 7'(s_row) * 7'(TILE_H) + 7'(s_y);
    if (!s_pat[s_col])  px_color = BG_COLOR;
    else if (s_aen)     px_color = s_acol;
    else                px_color = FG_COLOR;
`ifdef TILE_BORDER_EN
    if (s_x == '0 || s_x == XW'(TILE_W-1) || s_y == '0 || s_y == YW'(TILE_H-1))
      px_color = 9'h000;
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      g_idx     <= '0;
      row_q     <= '0;
      pat_q     <= '0;
      acc_en_q  <= 1'b0;
      acc_col_q <= '0;
      col       <= '0;
      xoff      <= '0;
      yoff      <= '0;
      grant     <= '0;
      done      <= '0;
      plot      <= 1'b0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= BG_COLOR;
    end else begin
      case (state)
        S_IDLE: begin
          plot <= 1'b0;
          done <= '0;
          if (sel_found) begin
            g_idx <= sel_idx;
            grant <= NUM_REQ'(1) << sel_idx;
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          row_q     <= s_row;
          pat_q     <= s_pat;
          acc_en_q  <= s_aen;
          acc_col_q <= s_acol;
          col       <= '0;
          xoff      <= '0;
          yoff      <= '0;
          plot      <= 1'b1;
          VGA_X     <= px_x;
          VGA_Y     <= px_y;
          VGA_COLOR <= px_color;
          state     <= S_DRAW;
        end
        S_DRAW: begin
          if (row_last) begin
            plot  <= 1'b0;
            grant <= '0;
            done  <= grant;
            state <= S_DONE;
          end else begin
            col       <= col_n;
            xoff      <= xoff_n;
            yoff      <= yoff_n;
            VGA_X     <= px_x;
            VGA_Y     <= px_y;
            VGA_COLOR <= px_color;
          end
        end
        default: begin
          done   <= '0;
          rr_ptr <= (g_idx == IW'(NUM_REQ-1)) ? '0 : g_idx + 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
